// File: rtl/inst_encoder_loader.sv
`default_nettype none
// inst_encoder_loader: packs decoded I/U/S/B fields into 32-bit words and writes them
// sequentially into instruction memory. Macro RV_BTYPE_EN enables B-type (fmt=3) encoding.
module inst_encoder_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err_range,
    output logic                  err_fmt
);

    localparam logic [1:0] FMT_I = 2'd0;
    localparam logic [1:0] FMT_U = 2'd1;
    localparam logic [1:0] FMT_S = 2'd2;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t                state;
    logic [1:0]            f_fmt;
    logic [6:0]            f_opcode;
    logic [4:0]            f_rd;
    logic [4:0]            f_rs1;
    logic [4:0]            f_rs2;
    logic [2:0]            f_funct3;
    logic [DATA_WIDTH-1:0] f_imm;

    logic [DATA_WIDTH-1:0] word;
    logic                  imm_ok;
    logic                  fmt_ok;
    logic [ADDR_WIDTH:0]   count_inc;

    assign count_inc = count + 1'b1;
    assign s_ready   = rst_n && !clear && (state == IDLE);

    always_comb begin
        word   = '0;
        imm_ok = 1'b0;
        fmt_ok = 1'b1;
        case (f_fmt)
            FMT_I: begin
                word   = {f_imm[11:0], f_rs1, f_funct3, f_rd, f_opcode};
                imm_ok = (f_imm[31:11] == {21{f_imm[11]}});
            end
            FMT_U: begin
                word   = {f_imm[31:12], f_rd, f_opcode};
                imm_ok = (f_imm[11:0] == 12'd0);
            end
            FMT_S: begin
                word   = {f_imm[11:5], f_rs2, f_rs1, f_funct3, f_imm[4:0], f_opcode};
                imm_ok = (f_imm[31:11] == {21{f_imm[11]}});
            end
            default: begin
`ifdef RV_BTYPE_EN
                word   = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_funct3,
                          f_imm[4:1], f_imm[11], f_opcode};
                imm_ok = !f_imm[0] && (f_imm[31:12] == {20{f_imm[12]}});
`else
                fmt_ok = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f_fmt     <= '0;
            f_opcode  <= '0;
            f_rd      <= '0;
            f_rs1     <= '0;
            f_rs2     <= '0;
            f_funct3  <= '0;
            f_imm     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
            err_range <= 1'b0;
            err_fmt   <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            mem_addr <= count[ADDR_WIDTH-1:0];
            if (clear) begin
                state     <= IDLE;
                count     <= '0;
                mem_addr  <= '0;
                full      <= 1'b0;
                err_range <= 1'b0;
                err_fmt   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_valid) begin
                            f_fmt    <= fmt;
                            f_opcode <= opcode;
                            f_rd     <= rd;
                            f_rs1    <= rs1;
                            f_rs2    <= rs2;
                            f_funct3 <= funct3;
                            f_imm    <= imm;
                            state    <= ENCODE;
                        end
                    end
                    ENCODE: begin
                        if (!fmt_ok) begin
                            err_fmt <= 1'b1;
                            state   <= IDLE;
                        end else if (!imm_ok) begin
                            err_range <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        // Address is the pre-increment count; FULL blocks any write past the end.
                        mem_we    <= 1'b1;
                        mem_wdata <= word;
                        count     <= count_inc;
                        full      <= (count_inc == DEPTH);
                        state     <= (count_inc == DEPTH) ? FULL : IDLE;
                    end
                    default: state <= FULL;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// Scoreboard bench for inst_encoder_loader (MEM_DEPTH=4); expected writes are queued at issue time.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n, clear, s_valid, s_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic        full, err_range, err_fmt;

    int total = 0;
    int bad   = 0;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    inst_encoder_loader #(.DATA_WIDTH(32), .MEM_DEPTH(4), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err_range(err_range), .err_fmt(err_fmt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL write got=%0d:%h want=%0d:%h", mem_addr, mem_wdata, e[37:32], e[31:0]);
                end
            end
        end
    end

    // Handshake only: returns 1 time unit after the transfer edge.
    task automatic xfer(input logic [1:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] f3,
                        input logic [31:0] im);
        int guard = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (s_ready !== 1'b1) chk("ready_timeout", {63'd0, s_ready}, 64'd1);
        fmt = f; opcode = op; rd = d; rs1 = a1; rs2 = a2; funct3 = f3; imm = im;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] f3,
                        input logic [31:0] im, input bit wr, input logic [5:0] a,
                        input logic [31:0] w);
        if (wr) exp_q.push_back({a, w});
        xfer(f, op, d, a1, a2, f3, im);
        @(negedge clk);
        chk("ready_low_c0", {63'd0, s_ready}, 64'd0);
        chk("we_c0", {63'd0, mem_we}, 64'd0);
        @(negedge clk);
        if (wr) chk("ready_low_c1", {63'd0, s_ready}, 64'd0);
        chk("we_c1", {63'd0, mem_we}, 64'd0);
        @(negedge clk);
        chk("we_c2", {63'd0, mem_we}, {63'd0, wr});
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_count", {57'd0, count}, 64'd0);
        chk("rst_flags", {61'd0, full, err_range, err_fmt}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", {63'd0, s_ready}, 64'd1);

        // I-type basic
        send(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 6'd0, 32'h00500093);
        chk("count_t1", {57'd0, count}, 64'd1);

        // U then S
        send(2'd1, 7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 32'h12345000, 1'b1, 6'd1, 32'h12345117);
        send(2'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8, 1'b1, 6'd2, 32'h00512423);
        chk("count_t2", {57'd0, count}, 64'd3);

        // Range rejections
        send(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0, 6'd0, 32'd0);
        send(2'd1, 7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 32'h00000001, 1'b0, 6'd0, 32'd0);
        chk("err_range_t3", {63'd0, err_range}, 64'd1);
        chk("err_fmt_t3", {63'd0, err_fmt}, 64'd0);
        chk("count_t3", {57'd0, count}, 64'd3);
        do_clear();
        chk("clr_err_range", {63'd0, err_range}, 64'd0);
        chk("clr_count", {57'd0, count}, 64'd0);
        chk("clr_addr", {58'd0, mem_addr}, 64'd0);

        // B-type
`ifdef RV_BTYPE_EN
        send(2'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 1'b1, 6'd0, 32'hFE208EE3);
        chk("count_b", {57'd0, count}, 64'd1);
        send(2'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0, 6'd0, 32'd0);
        chk("err_range_b", {63'd0, err_range}, 64'd1);
        chk("err_fmt_b", {63'd0, err_fmt}, 64'd0);
        chk("count_b2", {57'd0, count}, 64'd1);
`else
        send(2'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 1'b0, 6'd0, 32'd0);
        chk("err_fmt_b", {63'd0, err_fmt}, 64'd1);
        chk("err_range_b", {63'd0, err_range}, 64'd0);
        chk("count_b", {57'd0, count}, 64'd0);
`endif
        do_clear();
        chk("clr_err_fmt", {63'd0, err_fmt}, 64'd0);

        // Fill to MEM_DEPTH=4, then a fifth bundle must stall
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'(i), 1'b1, 6'(i),
                 32'h00000093 | (32'(i) << 20));
        end
        chk("full_set", {63'd0, full}, 64'd1);
        chk("count_full", {57'd0, count}, 64'd4);
        fmt = 2'd0; opcode = 7'b0010011; rd = 5'd1; imm = 32'd4;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("ready_full", {63'd0, s_ready}, 64'd0);
        chk("count_full2", {57'd0, count}, 64'd4);
        s_valid = 1'b0;
        do_clear();
        chk("clr_full", {63'd0, full}, 64'd0);
        chk("clr_count2", {57'd0, count}, 64'd0);
        send(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 6'd0, 32'h00500093);
        chk("count_after_full", {57'd0, count}, 64'd1);

        // clear during ENCODE drops the word
        xfer(2'd0, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd6);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("enc_clr_count", {57'd0, count}, 64'd0);
        chk("enc_clr_addr", {58'd0, mem_addr}, 64'd0);
        chk("enc_clr_ready", {63'd0, s_ready}, 64'd1);
        send(2'd0, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd7, 1'b1, 6'd0, 32'h00700193);

        // reset during WRITE
        xfer(2'd0, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'd9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("wr_rst_we", {63'd0, mem_we}, 64'd0);
        chk("wr_rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("wr_rst_count", {57'd0, count}, 64'd0);
        chk("wr_rst_addr", {58'd0, mem_addr}, 64'd0);
        chk("wr_rst_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 6'd0, 32'h00500093);
        chk("count_after_rst", {57'd0, count}, 64'd1);

        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Inverse of the immediate generator. It accepts decoded instruction fields (format, opcode, registers, funct, full-width immediate) over a valid/ready handshake. It re-packs the immediate into its format-specific bit positions, range-checks it, and writes the encoded 32-bit word sequentially into instruction memory. It is used by the bench and bring-up path to load test programs into the single-cycle CPU's instruction memory without an external assembler.

Parameters:
DATA_WIDTH, 32, instruction/immediate width (only 32 supported)
MEM_DEPTH, 64, number of instruction words the loader may write
ADDR_WIDTH, 6, word-address width; MEM_DEPTH must be at most 2**ADDR_WIDTH

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  sync: abort in-flight word, zero address/count, clear error flags
s_valid  in  1  field bundle valid
s_ready  out  1  loader can accept a bundle
fmt  in  2  0=I, 1=U, 2=S, 3=B
opcode  in  7  inst[6:0]
rd  in  5  inst[11:7] (I/U)
rs1  in  5  inst[19:15] (I/S/B)
rs2  in  5  inst[24:20] (S/B)
funct3  in  3  inst[14:12] (I/S/B)
imm  in  DATA_WIDTH  full signed immediate / byte offset
mem_we  out  1  one-cycle instruction-memory write strobe
mem_addr  out  ADDR_WIDTH  word address (byte PC = mem_addr*4)
mem_wdata  out  DATA_WIDTH  encoded instruction
count  out  ADDR_WIDTH+1  words written since reset/clear
full  out  1  count == MEM_DEPTH
err_range  out  1  sticky: a bundle was rejected for immediate range/alignment
err_fmt  out  1  sticky: unsupported format rejected

Behaviour:
- Reset (rst_n low, async): state IDLE. mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err_range=0, err_fmt=0. s_ready=0 while in reset.
- FSM states: IDLE, ENCODE, WRITE, FULL.
- IDLE: s_ready = !clear. A transfer occurs on s_valid&&s_ready. All field inputs are registered on the transfer, then the state moves to ENCODE. s_ready=0 in every other state.
- ENCODE (one cycle): build the word from the registered fields.
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - U: {imm[31:12], rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Range checks in ENCODE:
  - I/S: imm must equal the sign-extension of imm[11:0].
  - U: imm[11:0] must be 0.
  - B: imm[0] must be 0, and imm must equal the sign-extension of imm[12:0].
- ENCODE exits: if the check passes, go to WRITE. If it fails, set err_range, write nothing, return to IDLE.
- WRITE (one cycle): mem_we=1, mem_addr=count[ADDR_WIDTH-1:0], mem_wdata=word. On the same edge count increments. Next state is FULL if the new count equals MEM_DEPTH, otherwise IDLE.
- Latency: transfer at edge N, mem_we high during cycle N+2. Peak throughput is one word per 3 cycles.
- mem_wdata holds its last value when mem_we=0. mem_addr tracks count outside WRITE.
- FULL: full=1, s_ready=0. The only exits are clear or reset. No write ever occurs at address >= MEM_DEPTH.
- clear has highest priority in every state. Next state IDLE; count=0, mem_addr=0, error flags=0, mem_we forced 0 that cycle. An in-flight word is dropped. clear together with s_valid in IDLE produces no transfer.
- err_fmt and err_range are sticky until clear or reset. A rejected bundle does not advance count.
- opcode is passed through unchecked; only fmt selects packing.

Optional Feature:
RV_BTYPE_EN
- Defined: fmt=3 is encoded as B-type with the checks above.
- Undefined: fmt=3 is accepted over the handshake but rejected in ENCODE. err_fmt is set, no write occurs, count is unchanged, and the FSM returns to IDLE. The B-type packing logic is not synthesised.

Test Plan:
1. Reset, then I: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> mem_we at N+2, addr 0, wdata 0x00500093, count=1.
2. U: opcode=0010111, rd=2, imm=0x12345000, then S: opcode=0100011, funct3=2, rs1=2, rs2=5, imm=8 -> addr1=0x12345117, addr2=0x00512423, s_ready low 2 cycles after each transfer.
3. I with imm=2048, then U with imm=0x00000001 -> no mem_we, err_range=1, count unchanged; clear -> err_range=0.
4. B: opcode=1100011, funct3=0, rs1=1, rs2=2, imm=-4 -> with RV_BTYPE_EN wdata 0xFE208EE3; without it err_fmt=1 and no write. Also imm=3 with macro -> err_range=1.
5. MEM_DEPTH=4: five valid I bundles -> four writes at addr 0..3, full=1, s_ready stuck low; clear -> count=0, next write at addr 0.
6. clear asserted in the ENCODE cycle, and separately rst_n dropped in the WRITE cycle -> no mem_we, all outputs at reset/clear values, next bundle lands at addr 0.
